// File: rtl/tdc_collect_pkg.sv
// rtl/tdc_collect_pkg.sv - shared entry type and width helpers for the TDC result collector
package tdc_collect_pkg;

  localparam int DEF_DATA_W = 19;
  localparam int DEF_NUM_W  = 3;

  // One buffered TDC result; num sits above data so {num, data} packs naturally.
  typedef struct packed {
    logic [DEF_NUM_W-1:0]  num;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  // $clog2 that never returns 0, so a select for a 1- or 2-entry set still has a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // FIFO level needs one extra bit to represent "completely full".
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the channel tag on the merged stream.
  function automatic int ch_width(input int n_ch);
    return clog2_min1(n_ch);
  endfunction

endpackage

// File: rtl/tdc_ch_fifo.sv
// rtl/tdc_ch_fifo.sv - per-channel circular result buffer with level output
module tdc_ch_fifo
  import tdc_collect_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = entry_t,
  parameter int  LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  T                 i_wdata,
  input  logic             i_pop,
  output T                 o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a push at full is taken when paired with a pop.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_rd)      r_level <= r_level + LVL_W'(1);
      else if (w_rd && !w_wr) r_level <= r_level - LVL_W'(1);
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/tdc_multi_collect.sv
// rtl/tdc_multi_collect.sv - N-channel TDC collector: per-channel FIFOs, round-robin merge, sticky interrupts
module tdc_multi_collect
  import tdc_collect_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_W  = DEF_NUM_W,
  parameter int DEPTH  = 8,
  parameter int TMO_W  = 12,
  parameter int LVL_W  = lvl_width(DEPTH),
  parameter int CH_W   = ch_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH*DATA_W-1:0]  ch_data,
  input  logic [N_CH*NUM_W-1:0]   ch_num,
  output logic [N_CH-1:0]         ch_ready,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [LVL_W-1:0]        int_thr,
  input  logic [TMO_W-1:0]        tmo_cyc,
  input  logic [N_CH-1:0]         int_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [NUM_W-1:0]        out_num,
  output logic [CH_W-1:0]         out_ch,
  output logic [N_CH-1:0]         int_o,
  output logic [N_CH-1:0]         stall_o,
  output logic [N_CH*LVL_W-1:0]   level_o
);

  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } ch_entry_t;

  ch_entry_t        w_wdata [N_CH];
  ch_entry_t        w_rdata [N_CH];
  logic [LVL_W-1:0] w_level [N_CH];
  logic [TMO_W-1:0] r_tmo_cnt [N_CH];
  logic [N_CH-1:0]  w_full;
  logic [N_CH-1:0]  w_empty;
  logic [N_CH-1:0]  w_push;
  logic [N_CH-1:0]  w_pop;
  logic [N_CH-1:0]  w_stall_set;
  logic [N_CH-1:0]  w_thr_hit;
  logic [N_CH-1:0]  w_tmo_hit;

  logic             w_any;
  logic             w_load;
  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  r_rr_ptr;

  logic             r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [NUM_W-1:0] r_out_num;
  logic [CH_W-1:0]  r_out_ch;
  logic [N_CH-1:0]  r_int;
  logic [N_CH-1:0]  r_stall;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Disabled channels are always ready so an idle TDC never wedges; their data is dropped.
    assign ch_ready[g]    = ch_en[g] ? ~w_full[g] : 1'b1;
    assign w_push[g]      = ch_valid[g] & ch_ready[g] & ch_en[g];
    assign w_wdata[g]     = {ch_num[g*NUM_W +: NUM_W], ch_data[g*DATA_W +: DATA_W]};
    assign w_pop[g]       = w_load & (w_grant == CH_W'(g));
    assign level_o[g*LVL_W +: LVL_W] = w_level[g];

    assign w_stall_set[g] = ch_valid[g] & ~ch_ready[g] & ch_en[g];
    assign w_thr_hit[g]   = (int_thr != '0) & (w_level[g] >= int_thr);
    // Fires on the edge where the counter steps onto tmo_cyc, i.e. tmo_cyc cycles after the last push.
    assign w_tmo_hit[g]   = (tmo_cyc != '0) & (w_level[g] != '0) & ~w_push[g] &
                            (r_tmo_cnt[g] == tmo_cyc - TMO_W'(1));

    tdc_ch_fifo #(
      .DEPTH (DEPTH),
      .T     (ch_entry_t),
      .LVL_W (LVL_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_wdata (w_wdata[g]),
      .i_pop   (w_pop[g]),
      .o_rdata (w_rdata[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_level (w_level[g])
    );

    // Age of the oldest un-refreshed content: restarts on push or when empty, holds once it reaches tmo_cyc.
    always_ff @(posedge clk) begin
      if (rst || (w_level[g] == '0) || w_push[g]) begin
        r_tmo_cnt[g] <= '0;
      end else if (r_tmo_cnt[g] < tmo_cyc) begin
        r_tmo_cnt[g] <= r_tmo_cnt[g] + TMO_W'(1);
      end
    end
  end

  // Round-robin pick: first non-empty FIFO at or above the rotating start pointer.
  always_comb begin
    logic [CH_W-1:0] v_idx;
    w_any   = 1'b0;
    w_grant = '0;
    v_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      v_idx = CH_W'((int'(r_rr_ptr) + k) % N_CH);
      if (!w_any && !w_empty[v_idx]) begin
        w_any   = 1'b1;
        w_grant = v_idx;
      end
    end
  end

  assign w_load = (~r_out_valid | out_ready) & w_any;

  // Output register: refills whenever it is free or being consumed, and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_num   <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rdata[w_grant].data;
      r_out_num   <= w_rdata[w_grant].num;
      r_out_ch    <= w_grant;
      r_rr_ptr    <= CH_W'((int'(w_grant) + 1) % N_CH);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky interrupt and stall flags; a set condition in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int   <= '0;
      r_stall <= '0;
    end else begin
      r_int   <= (r_int & ~int_clr) | w_thr_hit | w_tmo_hit;
      r_stall <= (r_stall & ~int_clr) | w_stall_set;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_num   = r_out_num;
  assign out_ch    = r_out_ch;
  assign int_o     = r_int;
  assign stall_o   = r_stall;

endmodule

// File: tb/tb_tdc_multi_collect.sv
// tb/tb_tdc_multi_collect.sv - directed self-checking bench for tdc_multi_collect
module tb_tdc_multi_collect;

  localparam int N_CH   = 4;
  localparam int DATA_W = 19;
  localparam int NUM_W  = 3;
  localparam int DEPTH  = 8;
  localparam int TMO_W  = 12;
  localparam int LVL_W  = 4;
  localparam int CH_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH*NUM_W-1:0]  ch_num;
  logic [N_CH-1:0]        ch_ready;
  logic [N_CH-1:0]        ch_en;
  logic [LVL_W-1:0]       int_thr;
  logic [TMO_W-1:0]       tmo_cyc;
  logic [N_CH-1:0]        int_clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [NUM_W-1:0]       out_num;
  logic [CH_W-1:0]        out_ch;
  logic [N_CH-1:0]        int_o;
  logic [N_CH-1:0]        stall_o;
  logic [N_CH*LVL_W-1:0]  level_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
    logic [NUM_W-1:0]  num;
    logic [CH_W-1:0]   exp_ch;
    logic [LVL_W-1:0]  exp_lvl;
  } vec_t;

  vec_t vecs [4];
  int   exp_order [4];

  tdc_multi_collect #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .NUM_W  (NUM_W),
    .DEPTH  (DEPTH),
    .TMO_W  (TMO_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_num    (ch_num),
    .ch_ready  (ch_ready),
    .ch_en     (ch_en),
    .int_thr   (int_thr),
    .tmo_cyc   (tmo_cyc),
    .int_clr   (int_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_num   (out_num),
    .out_ch    (out_ch),
    .int_o     (int_o),
    .stall_o   (stall_o),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_lane(input int c, input logic [DATA_W-1:0] d, input logic [NUM_W-1:0] n);
    ch_valid[c] = 1'b1;
    ch_data[c*DATA_W +: DATA_W] = d;
    ch_num[c*NUM_W +: NUM_W] = n;
  endtask

  function automatic logic [LVL_W-1:0] lvl(input int c);
    return level_o[c*LVL_W +: LVL_W];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rx;
    bit acc;

    vecs[0] = '{ch: 2, data: 19'h1ABCD, num: 3'd3, exp_ch: 2'd2, exp_lvl: 4'd1};
    vecs[1] = '{ch: 0, data: 19'h00001, num: 3'd0, exp_ch: 2'd0, exp_lvl: 4'd1};
    vecs[2] = '{ch: 3, data: 19'h7FFFF, num: 3'd7, exp_ch: 2'd3, exp_lvl: 4'd1};
    vecs[3] = '{ch: 1, data: 19'h55555, num: 3'd5, exp_ch: 2'd1, exp_lvl: 4'd1};
    exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 0; exp_order[3] = 1;

    rst = 1'b1; ch_valid = '0; ch_data = '0; ch_num = '0; ch_en = '1;
    int_thr = '0; tmo_cyc = '0; int_clr = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_int",       32'(int_o),     32'd0);
    check("rst_stall",     32'(stall_o),   32'd0);
    check("rst_level",     32'(level_o),   32'd0);
    check("rst_ready",     32'(ch_ready),  32'hF);
    rst = 1'b0;
    tick();

    // Round robin from reset: ch0..ch3 on consecutive cycles
    for (int c = 0; c < 4; c++) drive_lane(c, DATA_W'(32'h100 + c), NUM_W'(c));
    tick();
    ch_valid = '0;
    check("rr_level", 32'(level_o), 32'h1111);
    check("rr_early_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_ch",    32'(out_ch),    32'(k));
      check("rr_data",  32'(out_data),  32'h100 + k);
    end
    tick();
    check("rr_idle", 32'(out_valid), 32'd0);

    // Move last grant to ch1, then all four again: 2, 3, 0, 1
    drive_lane(1, DATA_W'(32'h0AA), 3'd1);
    tick();
    ch_valid = '0;
    tick();
    check("rr2_pre_ch", 32'(out_ch), 32'd1);
    tick();
    for (int c = 0; c < 4; c++) drive_lane(c, DATA_W'(32'h300 + c), NUM_W'(c));
    tick();
    ch_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr2_ch",   32'(out_ch),   32'(exp_order[k]));
      check("rr2_data", 32'(out_data), 32'h300 + exp_order[k]);
    end
    tick();

    // Table: single push per channel, latency two edges
    for (int i = 0; i < 4; i++) begin
      drive_lane(vecs[i].ch, vecs[i].data, vecs[i].num);
      tick();
      ch_valid = '0;
      check("tbl_valid_t1", 32'(out_valid), 32'd0);
      check("tbl_level_t1", 32'(lvl(vecs[i].ch)), 32'(vecs[i].exp_lvl));
      tick();
      check("tbl_valid_t2", 32'(out_valid), 32'd1);
      check("tbl_data",     32'(out_data),  32'(vecs[i].data));
      check("tbl_num",      32'(out_num),   32'(vecs[i].num));
      check("tbl_ch",       32'(out_ch),    32'(vecs[i].exp_ch));
      check("tbl_level_t2", 32'(level_o),   32'd0);
      tick();
      check("tbl_idle", 32'(out_valid), 32'd0);
    end

    // Backpressure: 9 accepted (one in the output register, 8 in FIFO), 10th stalls
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive_lane(0, DATA_W'(32'h200 + k), 3'd0);
      tick();
    end
    ch_valid = '0;
    check("bp_ready_low", 32'(ch_ready[0]), 32'd0);
    check("bp_level",     32'(lvl(0)),      32'd8);
    check("bp_head",      32'(out_data),    32'h200);
    drive_lane(0, DATA_W'(32'h209), 3'd0);
    tick();
    check("bp_stall", 32'(stall_o), 32'h1);
    check("bp_level_hold", 32'(lvl(0)), 32'd8);
    check("bp_head_hold", 32'(out_data), 32'h200);
    out_ready = 1'b1;
    n_rx = 0;
    for (int cyc = 0; cyc < 40 && n_rx < 10; cyc++) begin
      acc = ch_valid[0] & ch_ready[0];
      if (out_valid) begin
        check("bp_data", 32'(out_data), 32'h200 + n_rx);
        n_rx++;
      end
      tick();
      if (acc) ch_valid[0] = 1'b0;
    end
    check("bp_count", 32'(n_rx), 32'd10);
    check("bp_drained", 32'(level_o), 32'd0);
    check("bp_stall_sticky", 32'(stall_o), 32'h1);
    int_clr[0] = 1'b1;
    tick();
    int_clr = '0;
    check("bp_stall_clr", 32'(stall_o), 32'd0);

    // Threshold interrupt on ch1 at level 4, set wins over clear
    int_thr = 4'd4;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_lane(1, DATA_W'(32'h400 + k), 3'd1);
      tick();
      if (k == 3) begin
        check("thr_lvl3", 32'(lvl(1)), 32'd3);
        check("thr_int_lvl3", 32'(int_o), 32'd0);
      end
      if (k == 4) begin
        check("thr_lvl4", 32'(lvl(1)), 32'd4);
        check("thr_int_same", 32'(int_o), 32'd0);
      end
    end
    ch_valid = '0;
    tick();
    check("thr_int_set", 32'(int_o), 32'h2);
    int_clr[1] = 1'b1;
    tick();
    int_clr = '0;
    check("thr_set_wins", 32'(int_o), 32'h2);
    out_ready = 1'b1;
    repeat (6) tick();
    check("thr_drained", 32'(level_o), 32'd0);
    int_clr[1] = 1'b1;
    tick();
    int_clr = '0;
    check("thr_cleared", 32'(int_o), 32'd0);
    int_thr = '0;

    // Timeout: second ch3 entry stays in FIFO, interrupt exactly 10 edges after its push
    tmo_cyc = 12'd10;
    out_ready = 1'b0;
    drive_lane(3, DATA_W'(32'h500), 3'd3);
    tick();
    drive_lane(3, DATA_W'(32'h501), 3'd3);
    tick();
    ch_valid = '0;
    check("tmo_lvl", 32'(lvl(3)), 32'd1);
    repeat (9) tick();
    check("tmo_early", 32'(int_o), 32'd0);
    tick();
    check("tmo_set", 32'(int_o), 32'h8);
    tmo_cyc = '0;
    int_clr[3] = 1'b1;
    tick();
    int_clr = '0;
    repeat (20) tick();
    check("tmo_off", 32'(int_o), 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("tmo_drained", 32'(level_o), 32'd0);

    // Disabled channel: always ready, data discarded
    ch_en = 4'b1110;
    #1;
    check("dis_ready", 32'(ch_ready[0]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive_lane(0, DATA_W'(32'h600 + k), 3'd0);
      tick();
      check("dis_no_out", 32'(out_valid), 32'd0);
      check("dis_level",  32'(lvl(0)),   32'd0);
    end
    ch_valid = '0;
    tick();
    check("dis_stall", 32'(stall_o), 32'd0);
    ch_en = '1;

    // Reset mid-burst
    int_thr = 4'd1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) drive_lane(c, DATA_W'(32'h700 + 4*k + c), NUM_W'(c));
      tick();
    end
    ch_valid = '0;
    check("mid_level", 32'(level_o), 32'h3332);
    check("mid_int",   32'(int_o),   32'hF);
    check("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_int",   32'(int_o),     32'd0);
    check("mrst_level", 32'(level_o),   32'd0);
    check("mrst_data",  32'(out_data),  32'd0);
    check("mrst_ready", 32'(ch_ready),  32'hF);
    int_thr = '0;
    out_ready = 1'b1;
    tick();
    check("mrst_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
